pll_lock_reset_sequencer: RTL and testbench

PLL_LOCK_RESET_SEQUENCER -- requirements
Module: pll_lock_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 17 +
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_reset_sequencer.sv | 111 +++++++++++
 tb/tb_pll_lock_reset_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock / reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock, then releases the downstream reset;
// retries on lock timeout and parks in FAULT after too many consecutive failures.
module pll_lock_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked_in,
  input  logic       clear_fault,
  output logic       pll_rst_out,
  output logic       sys_rst_out,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_count
);

  localparam int RST_W   = $clog2(PLL_RST_CYCLES + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  state_t             state, state_nxt;
  logic               locked_s;
  logic               timeout_hit;
  logic [RST_W-1:0]   rst_cnt;
  logic [TO_W-1:0]    timeout_cnt;
  logic [STB_W-1:0]   stable_cnt;
  logic [RETRY_W-1:0] retry_cnt;

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked_in),
    .q   (locked_s)
  );

  assign timeout_hit = (state == ST_WAIT_LOCK) && !locked_s && (timeout_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PLL_RST:   if (rst_cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (locked_s)         state_nxt = ST_STABLE;
        else if (timeout_hit) state_nxt = (retry_cnt == RETRY_LAST) ? ST_FAULT : ST_PLL_RST;
      end
      ST_STABLE: begin
        if (!locked_s)                state_nxt = ST_WAIT_LOCK;
        else if (stable_cnt == STB_LAST) state_nxt = ST_RUN;
      end
      ST_RUN:       if (!locked_s) state_nxt = ST_PLL_RST;
      ST_FAULT:     if (clear_fault) state_nxt = ST_PLL_RST;
      default:      state_nxt = ST_PLL_RST;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state           <= ST_PLL_RST;
      rst_cnt         <= '0;
      timeout_cnt     <= '0;
      stable_cnt      <= '0;
      retry_cnt       <= '0;
      lock_loss_count <= '0;
      pll_rst_out     <= 1'b1;
      sys_rst_out     <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state <= state_nxt;

      // Counters only run while their own state persists, so any entry restarts them at 0.
      rst_cnt     <= '0;
      timeout_cnt <= '0;
      stable_cnt  <= '0;
      if (state_nxt == state) begin
        case (state)
          ST_PLL_RST:   rst_cnt     <= rst_cnt + 1'b1;
          ST_WAIT_LOCK: timeout_cnt <= timeout_cnt + 1'b1;
          ST_STABLE:    stable_cnt  <= stable_cnt + 1'b1;
          default: ;
        endcase
      end

      if (timeout_hit)
        retry_cnt <= retry_cnt + 1'b1;
      else if ((state_nxt == ST_RUN && state != ST_RUN) || (state == ST_FAULT && clear_fault))
        retry_cnt <= '0;

      if (state == ST_RUN && !locked_s && lock_loss_count != 8'hFF)
        lock_loss_count <= lock_loss_count + 8'd1;

      // Outputs are decoded from the next state so they change on the same edge as the state.
      pll_rst_out <= (state_nxt == ST_PLL_RST) || (state_nxt == ST_FAULT);
      sys_rst_out <= (state_nxt != ST_RUN);
      ready       <= (state_nxt == ST_RUN);
      fault       <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Self-checking bench for pll_lock_reset_sequencer: directed scenarios plus a
// randomized run compared against a phase/elapsed-time reference model.
module tb_pll_lock_reset_sequencer;

  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_TIMEOUT_CYCLES = 32;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int MAX_RETRIES         = 3;

  localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked_in = 1'b0;
  logic       clear_fault = 1'b0;
  logic       pll_rst_out, sys_rst_out, ready, fault;
  logic [7:0] lock_loss_count;

  int checks = 0;
  int passes = 0;

  pll_lock_reset_sequencer #(
    .PLL_RST_CYCLES      (PLL_RST_CYCLES),
    .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
    .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
    .MAX_RETRIES         (MAX_RETRIES)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked_in   (pll_locked_in),
    .clear_fault     (clear_fault),
    .pll_rst_out     (pll_rst_out),
    .sys_rst_out     (sys_rst_out),
    .ready           (ready),
    .fault           (fault),
    .lock_loss_count (lock_loss_count)
  );

  always #20 refclk = ~refclk;

  // Reference model: phase plus cycles elapsed in it; lock is seen two edges late.
  int   m_phase = P_RST, m_cyc = 0, m_retry = 0, m_loss = 0;
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_ls = 1'b0;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase = P_RST; m_cyc = 0; m_retry = 0; m_loss = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      m_ls = m_s2; m_s2 = m_s1; m_s1 = pll_locked_in;
      m_cyc = m_cyc + 1;
      case (m_phase)
        P_RST: if (m_cyc == PLL_RST_CYCLES) begin m_phase = P_WAIT; m_cyc = 0; end
        P_WAIT: begin
          if (m_ls) begin m_phase = P_STABLE; m_cyc = 0; end
          else if (m_cyc == LOCK_TIMEOUT_CYCLES) begin
            m_retry = m_retry + 1;
            m_phase = (m_retry == MAX_RETRIES) ? P_FAULT : P_RST;
            m_cyc = 0;
          end
        end
        P_STABLE: begin
          if (!m_ls) begin m_phase = P_WAIT; m_cyc = 0; end
          else if (m_cyc == LOCK_STABLE_CYCLES) begin m_phase = P_RUN; m_retry = 0; m_cyc = 0; end
        end
        P_RUN: if (!m_ls) begin
          if (m_loss < 255) m_loss = m_loss + 1;
          m_phase = P_RST; m_cyc = 0;
        end
        P_FAULT: if (clear_fault) begin m_retry = 0; m_phase = P_RST; m_cyc = 0; end
        default: m_phase = P_RST;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked_in = 1'b0; clear_fault = 1'b0;
    tick(); tick();
    checks++; if (pll_rst_out !== 1'b1) $display("FAIL reset_pll_rst: got %b want 1", pll_rst_out); else passes++;
    checks++; if (sys_rst_out !== 1'b1) $display("FAIL reset_sys_rst: got %b want 1", sys_rst_out); else passes++;
    checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else passes++;
    checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else passes++;
    checks++; if (lock_loss_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", lock_loss_count); else passes++;
  endtask

  task automatic test_release();
    int n, edges;
    pll_locked_in = 1'b0; clear_fault = 1'b0;
    do_reset();
    n = 0;
    while (pll_rst_out === 1'b1 && n < 50) begin n++; tick(); end
    checks++; if (n != 4) $display("FAIL release_pll_rst_width: got %0d want 4", n); else passes++;
    pll_locked_in = 1'b1;
    edges = 0;
    while (ready !== 1'b1 && edges < 50) begin tick(); edges++; end
    checks++; if (edges != 11) $display("FAIL release_latency: got %0d want 11", edges); else passes++;
    checks++; if (sys_rst_out !== 1'b0) $display("FAIL release_sys_rst: got %b want 0", sys_rst_out); else passes++;
    checks++; if (pll_rst_out !== 1'b0) $display("FAIL release_pll_rst: got %b want 0", pll_rst_out); else passes++;
  endtask

  task automatic test_timeout_fault();
    int   cyc, run, n;
    logic level;
    int   runs[$];
    int   exp_runs[6];
    exp_runs = '{4, 32, 4, 32, 4, 32};
    pll_locked_in = 1'b0; clear_fault = 1'b0;
    do_reset();
    level = pll_rst_out; run = 0; cyc = 0;
    while (fault !== 1'b1 && cyc < 400) begin
      if (pll_rst_out === level) run++;
      else begin runs.push_back(run); level = pll_rst_out; run = 1; end
      clear_fault = (cyc == 50);  // must be ignored outside FAULT
      tick(); cyc++;
    end
    clear_fault = 1'b0;
    runs.push_back(run);
    checks++; if (cyc != 108) $display("FAIL fault_entry_cycle: got %0d want 108", cyc); else passes++;
    checks++; if (runs.size() != 6) $display("FAIL fault_run_count: got %0d want 6", runs.size()); else passes++;
    for (int i = 0; i < runs.size() && i < 6; i++) begin
      checks++;
      if (runs[i] != exp_runs[i]) $display("FAIL fault_run_%0d: got %0d want %0d", i, runs[i], exp_runs[i]);
      else passes++;
    end
    checks++; if (pll_rst_out !== 1'b1) $display("FAIL fault_pll_rst: got %b want 1", pll_rst_out); else passes++;
    checks++; if (sys_rst_out !== 1'b1) $display("FAIL fault_sys_rst: got %b want 1", sys_rst_out); else passes++;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (fault !== 1'b1) $display("FAIL fault_hold: got %b want 1", fault); else passes++;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    checks++; if (fault !== 1'b0) $display("FAIL fault_clear: got %b want 0", fault); else passes++;
    n = 0;
    while (pll_rst_out === 1'b1 && n < 50) begin n++; tick(); end
    checks++; if (n != 4) $display("FAIL fault_restart_width: got %0d want 4", n); else passes++;
  endtask

  task automatic test_lock_loss();
    int edges, misses;
    pll_locked_in = 1'b1; clear_fault = 1'b0;
    do_reset();
    edges = 0;
    while (ready !== 1'b1 && edges < 100) begin tick(); edges++; end
    checks++; if (ready !== 1'b1) $display("FAIL loss_initial_run: got %b want 1", ready); else passes++;
    for (int i = 0; i < 3; i++) begin
      pll_locked_in = 1'b0; edges = 0;
      while (ready === 1'b1 && edges < 20) begin tick(); edges++; end
      checks++; if (edges != 3) $display("FAIL loss_drop_latency_%0d: got %0d want 3", i, edges); else passes++;
      checks++; if (sys_rst_out !== 1'b1) $display("FAIL loss_sys_rst_%0d: got %b want 1", i, sys_rst_out); else passes++;
      pll_locked_in = 1'b1; edges = 0;
      while (ready !== 1'b1 && edges < 100) begin tick(); edges++; end
      checks++; if (ready !== 1'b1) $display("FAIL loss_relock_%0d: got %b want 1", i, ready); else passes++;
    end
    checks++; if (lock_loss_count !== 8'd3) $display("FAIL loss_count_3: got %0d want 3", lock_loss_count); else passes++;
    misses = 0;
    for (int i = 3; i < 300; i++) begin
      pll_locked_in = 1'b0; edges = 0;
      while (ready === 1'b1 && edges < 20) begin tick(); edges++; end
      if (ready !== 1'b0) misses++;
      pll_locked_in = 1'b1; edges = 0;
      while (ready !== 1'b1 && edges < 100) begin tick(); edges++; end
      if (ready !== 1'b1) misses++;
    end
    checks++; if (misses != 0) $display("FAIL loss_bulk_bounds: got %0d want 0", misses); else passes++;
    checks++; if (lock_loss_count !== 8'd255) $display("FAIL loss_saturate: got %0d want 255", lock_loss_count); else passes++;
  endtask

  task automatic test_stable_glitch();
    int edges, first, early;
    pll_locked_in = 1'b0; clear_fault = 1'b0;
    do_reset();
    edges = 0;
    while (pll_rst_out === 1'b1 && edges < 50) begin tick(); edges++; end
    first = 0; early = 0;
    for (int k = 1; k <= 22; k++) begin
      pll_locked_in = (k == 7 || k == 8) ? 1'b0 : 1'b1;
      tick();
      if (ready === 1'b1 && first == 0) first = k;
      if (ready === 1'b1 && k < 19) early++;
    end
    checks++; if (first != 19) $display("FAIL glitch_requalify: got %0d want 19", first); else passes++;
    checks++; if (early != 0) $display("FAIL glitch_early_ready: got %0d want 0", early); else passes++;
    checks++; if (pll_rst_out !== 1'b0) $display("FAIL glitch_pll_rst: got %b want 0", pll_rst_out); else passes++;
  endtask

  task automatic test_async_reset();
    int edges, n;
    pll_locked_in = 1'b1; clear_fault = 1'b0;
    do_reset();
    edges = 0;
    while (pll_rst_out === 1'b1 && edges < 50) begin tick(); edges++; end
    for (int i = 0; i < 5; i++) tick();
    #5 rst = 1'b1;
    #1;
    checks++; if (pll_rst_out !== 1'b1) $display("FAIL arst_stable_pll_rst: got %b want 1", pll_rst_out); else passes++;
    checks++; if (sys_rst_out !== 1'b1) $display("FAIL arst_stable_sys_rst: got %b want 1", sys_rst_out); else passes++;
    tick();
    rst = 1'b0;
    n = 0;
    while (pll_rst_out === 1'b1 && n < 50) begin n++; tick(); end
    checks++; if (n != 4) $display("FAIL arst_restart_width: got %0d want 4", n); else passes++;
    edges = 0;
    while (ready !== 1'b1 && edges < 100) begin tick(); edges++; end
    pll_locked_in = 1'b0; edges = 0;
    while (ready === 1'b1 && edges < 20) begin tick(); edges++; end
    pll_locked_in = 1'b1; edges = 0;
    while (ready !== 1'b1 && edges < 100) begin tick(); edges++; end
    checks++; if (lock_loss_count !== 8'd1) $display("FAIL arst_pre_count: got %0d want 1", lock_loss_count); else passes++;
    #5 rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) $display("FAIL arst_run_ready: got %b want 0", ready); else passes++;
    checks++; if (sys_rst_out !== 1'b1) $display("FAIL arst_run_sys_rst: got %b want 1", sys_rst_out); else passes++;
    checks++; if (pll_rst_out !== 1'b1) $display("FAIL arst_run_pll_rst: got %b want 1", pll_rst_out); else passes++;
    checks++; if (fault !== 1'b0) $display("FAIL arst_run_fault: got %b want 0", fault); else passes++;
    checks++; if (lock_loss_count !== 8'd0) $display("FAIL arst_run_count: got %0d want 0", lock_loss_count); else passes++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int   seg_left, r;
    logic lvl, e_pll, e_sys, e_rdy, e_flt;
    pll_locked_in = 1'b0; clear_fault = 1'b0;
    do_reset();
    seg_left = 0; lvl = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      e_pll = (m_phase == P_RST) || (m_phase == P_FAULT);
      e_sys = (m_phase != P_RUN);
      e_rdy = (m_phase == P_RUN);
      e_flt = (m_phase == P_FAULT);
      checks++; if (pll_rst_out !== e_pll) $display("FAIL rand_pll_rst@%0d: got %b want %b", c, pll_rst_out, e_pll); else passes++;
      checks++; if (sys_rst_out !== e_sys) $display("FAIL rand_sys_rst@%0d: got %b want %b", c, sys_rst_out, e_sys); else passes++;
      checks++; if (ready !== e_rdy) $display("FAIL rand_ready@%0d: got %b want %b", c, ready, e_rdy); else passes++;
      checks++; if (fault !== e_flt) $display("FAIL rand_fault@%0d: got %b want %b", c, fault, e_flt); else passes++;
      checks++; if (lock_loss_count !== 8'(m_loss)) $display("FAIL rand_count@%0d: got %0d want %0d", c, lock_loss_count, m_loss); else passes++;
      if (seg_left == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6)      begin lvl = 1'b1; seg_left = $urandom_range(1, 40); end
        else if (r < 8) begin lvl = 1'b0; seg_left = $urandom_range(1, 5); end
        else            begin lvl = 1'b0; seg_left = $urandom_range(30, 130); end
      end
      seg_left--;
      pll_locked_in = lvl;
      clear_fault = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; clear_fault = 1'b0;
  endtask

  initial begin
    test_reset();
    test_release();
    test_timeout_fault();
    test_lock_loss();
    test_stable_glitch();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
